mips_control_fsm: RTL and testbench

Multicycle MIPS main controller that sequences every instruction through fetch, decode, execute, memory and write-back. Sits directly upstream of the register file: it produces the register-file write enable (RegWrite) and the write-address/data selects (RegDst, MemtoReg). It also drives the PC, IR, ALU-operand and memory controls of the data path. Memory accesses use a single-bit ready handshake, so fetch and load/store states can stall.

---
 rtl/mips_ctrl_pkg.sv | 56 +++++
 rtl/mips_ctrl_decode.sv | 71 +++++++
 rtl/mips_control_fsm.sv | 92 +++++++++
 tb/tb_mips_control_fsm.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller: state encodings,
// opcodes, ALU operation codes and the bundle of data-path controls.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Moore output decode: maps the controller state (plus MemReady in FETCH)
// to the data-path controls. Purely combinational.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state_t'(state))
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        // PC+4 and the instruction are only captured once memory delivers
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_BOFF;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS main controller: state register, next-state logic and
// reset gating of the write/request enables. Output decode lives in mips_ctrl_decode.
module mips_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_t     state;
  state_t     next_state;
  logic       illegal;
  logic [3:0] dec_state;
  ctrl_t      ctrl;

  always_ff @(posedge clock) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    illegal    = 1'b0;
    case (state)
      S_FETCH:     next_state = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDI_EXEC;
          default: begin
            next_state = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  next_state = (Op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  next_state = MemReady ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: next_state = MemReady ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   next_state = S_ALU_WB;
      S_ADDI_EXEC: next_state = S_ADDI_WB;
      default:     next_state = S_FETCH;
    endcase
  end

  // While reset is held the selects already show FETCH values, even before the edge lands
  assign dec_state = reset ? state : S_FETCH;

  mips_ctrl_decode u_decode (
    .state     (dec_state),
    .mem_ready (MemReady),
    .ctrl      (ctrl)
  );

  always_comb begin
    PCWrite     = ctrl.pc_write      & reset;
    PCWriteCond = ctrl.pc_write_cond & reset;
    MemRead     = ctrl.mem_read      & reset;
    MemWrite    = ctrl.mem_write     & reset;
    IRWrite     = ctrl.ir_write      & reset;
    RegWrite    = ctrl.reg_write     & reset;
    IllegalOp   = illegal            & reset;
    IorD        = ctrl.iord;
    MemtoReg    = ctrl.mem_to_reg;
    RegDst      = ctrl.reg_dst;
    ALUSrcA     = ctrl.alu_src_a;
    ALUSrcB     = ctrl.alu_src_b;
    ALUOp       = ctrl.alu_op;
    PCSrc       = ctrl.pc_src;
    State       = state;
  end

endmodule

// File: tb/tb_mips_control_fsm.sv
// Scoreboard bench for mips_control_fsm: each driven cycle pushes the expected
// state and control word; a monitor pops and compares mid-cycle.
module tb_mips_control_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] Op = 6'd0;
  logic       MemReady = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] State;

  mips_control_fsm dut (
    .clock       (clock),
    .reset       (reset),
    .Op          (Op),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSrc       (PCSrc),
    .IllegalOp   (IllegalOp),
    .State       (State)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctl;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;

  logic [17:0] obs_ctl;
  assign obs_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, IllegalOp};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference control word per state, written straight from the control table
  function automatic logic [17:0] model(input logic [3:0] s, input logic mr,
                                        input logic rstn, input logic [5:0] op);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill;
    logic [1:0] srcb, aluop, pcsrc;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill} = '0;
    srcb = 2'b00; aluop = 2'b00; pcsrc = 2'b00;
    if (!rstn) begin
      srcb = 2'b01;
    end else begin
      case (s)
        4'd0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
        4'd1:  begin
          srcb = 2'b11;
          ill  = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                   op == 6'b000100 || op == 6'b000010 || op == 6'b001000);
        end
        4'd2:  begin srca = 1; srcb = 2'b10; end
        4'd3:  begin mrd = 1; iord = 1; end
        4'd4:  begin m2r = 1; rw = 1; end
        4'd5:  begin mwr = 1; iord = 1; end
        4'd6:  begin srca = 1; aluop = 2'b10; end
        4'd7:  begin rdst = 1; rw = 1; end
        4'd8:  begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
        4'd9:  begin pcw = 1; pcsrc = 2'b10; end
        4'd10: begin srca = 1; srcb = 2'b10; end
        4'd11: begin rw = 1; end
        default: ;
      endcase
    end
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, ill};
  endfunction

  task automatic step(input logic rstn, input logic mr, input logic [5:0] op, input logic [3:0] st);
    @(negedge clock);
    reset    = rstn;
    MemReady = mr;
    Op       = op;
    exp_q.push_back({st, model(st, mr, rstn, op)});
  endtask

  always @(negedge clock) begin
    #2;
    cycle++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_val($sformatf("state@%0d", cycle), {28'd0, State}, {28'd0, mon_e.st});
      check_val($sformatf("ctrl@%0d(st%0d)", cycle, mon_e.st), {14'd0, obs_ctl}, {14'd0, mon_e.ctl});
    end
  end

  initial begin
    // reset held two cycles
    step(0, 1, 6'h00, 4'd0);
    step(0, 1, 6'h00, 4'd0);
    // R-type; Op garbage after DECODE must be ignored
    step(1, 1, 6'h00, 4'd0);
    step(1, 1, 6'h00, 4'd1);
    step(1, 1, 6'h3F, 4'd6);
    step(1, 1, 6'h3F, 4'd7);
    // fetch stall, then LW with a two-cycle MEM_READ stall
    step(1, 0, 6'h23, 4'd0);
    step(1, 1, 6'h23, 4'd0);
    step(1, 1, 6'h23, 4'd1);
    step(1, 1, 6'h23, 4'd2);
    step(1, 0, 6'h23, 4'd3);
    step(1, 0, 6'h3F, 4'd3);
    step(1, 1, 6'h23, 4'd3);
    step(1, 1, 6'h23, 4'd4);
    // SW with one MEM_WRITE stall
    step(1, 1, 6'h2B, 4'd0);
    step(1, 1, 6'h2B, 4'd1);
    step(1, 1, 6'h2B, 4'd2);
    step(1, 0, 6'h2B, 4'd5);
    step(1, 1, 6'h2B, 4'd5);
    // BEQ, J, ADDI
    step(1, 1, 6'h04, 4'd0);
    step(1, 1, 6'h04, 4'd1);
    step(1, 1, 6'h04, 4'd8);
    step(1, 1, 6'h02, 4'd0);
    step(1, 1, 6'h02, 4'd1);
    step(1, 1, 6'h02, 4'd9);
    step(1, 1, 6'h08, 4'd0);
    step(1, 1, 6'h08, 4'd1);
    step(1, 1, 6'h08, 4'd10);
    step(1, 1, 6'h08, 4'd11);
    // illegal opcode
    step(1, 1, 6'h3F, 4'd0);
    step(1, 1, 6'h3F, 4'd1);
    // reset while stalled in MEM_WRITE
    step(1, 1, 6'h2B, 4'd0);
    step(1, 1, 6'h2B, 4'd1);
    step(1, 1, 6'h2B, 4'd2);
    step(1, 0, 6'h2B, 4'd5);
    step(0, 0, 6'h2B, 4'd5);
    // reset while stalled in MEM_READ
    step(1, 1, 6'h23, 4'd0);
    step(1, 1, 6'h23, 4'd1);
    step(1, 1, 6'h23, 4'd2);
    step(1, 0, 6'h23, 4'd3);
    step(0, 0, 6'h23, 4'd3);
    step(1, 1, 6'h00, 4'd0);
    step(1, 1, 6'h00, 4'd1);
    // let the monitor drain the queue
    @(negedge clock);
    #5;
    check_val("drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
